// File: rtl/pid_sched_if.sv
// pid_sched_if -- request/result bundle for the shared-multiplier PID scheduler.
//
// Signals:
//   req       per-channel one-cycle sample request pulses
//   sp_bus    packed signed setpoints, channel i at [i*VAL_LENGTH +: VAL_LENGTH]
//   fb_bus    packed signed feedbacks, same packing as sp_bus
//   out_valid result available (driven by the scheduler)
//   out_ready consumer accepts the result
//   out_ch    channel number of the current result
//   out_val   signed saturated control output
//
// Modports:
//   master  the request producer / result consumer side
//   slave   the scheduler side
interface pid_sched_if #(
  parameter int VAL_LENGTH = 32,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*VAL_LENGTH-1:0] sp_bus;
  logic [NUM_CH*VAL_LENGTH-1:0] fb_bus;
  logic                         out_valid;
  logic                         out_ready;
  logic [CH_W-1:0]              out_ch;
  logic signed [VAL_LENGTH-1:0] out_val;

  modport master (
    output req, sp_bus, fb_bus, out_ready,
    input  out_valid, out_ch, out_val
  );

  modport slave (
    input  req, sp_bus, fb_bus, out_ready,
    output out_valid, out_ch, out_val
  );
endinterface

// File: rtl/pid_sched.sv
// pid_sched -- time-multiplexed PID controller serving NUM_CH channels with a
// single signed VAL_LENGTH x VAL_LENGTH multiplier.
//
// Ports:
//   sys_clk     clock, all state on the rising edge
//   sys_rst_n   asynchronous active-low reset
//   bus         pid_sched_if.slave: requests, setpoint/feedback buses, result handshake
//   kp, ki, kd  shared signed fixed-point gains with FRAC fractional bits
//   int_max/int_min  clamp limits of the per-channel integrator
//   out_max/out_min  clamp limits of the control output
//   busy        high whenever the sequencer is not idle
//
// Build option:
//   PID_ANTIWINDUP_EN  when defined, a channel whose last output saturated stops
//                      integrating errors that push further into that saturation.
//
// Sequence per sample: IDLE(grant) -> ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> OUT.
module pid_sched #(
  parameter int VAL_LENGTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FRAC       = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  pid_sched_if.slave                   bus,
  input  logic signed [VAL_LENGTH-1:0] kp,
  input  logic signed [VAL_LENGTH-1:0] ki,
  input  logic signed [VAL_LENGTH-1:0] kd,
  input  logic signed [VAL_LENGTH-1:0] int_max,
  input  logic signed [VAL_LENGTH-1:0] int_min,
  input  logic signed [VAL_LENGTH-1:0] out_max,
  input  logic signed [VAL_LENGTH-1:0] out_min,
  output logic                         busy
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W  = VAL_LENGTH + 2;
  localparam int PROD_W = 2 * VAL_LENGTH;

  // Bounds of a VAL_LENGTH-bit signed value, expressed at product width.
  localparam logic signed [PROD_W-1:0] TERM_MAX = {{(VAL_LENGTH+1){1'b0}}, {(VAL_LENGTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] TERM_MIN = {{(VAL_LENGTH+1){1'b1}}, {(VAL_LENGTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_SAT, S_OUT
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_CH-1:0]            pending_q, pending_d;
  logic [CH_W-1:0]              last_grant_q, last_grant_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic signed [VAL_LENGTH-1:0] sp_q, sp_d, fb_q, fb_d;
  logic signed [VAL_LENGTH-1:0] ek0_q, ek0_d, acc_q, acc_d, dif_q, dif_d;
  logic signed [VAL_LENGTH-1:0] out_val_q, out_val_d;
  logic signed [SUM_W-1:0]      sum_q, sum_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [VAL_LENGTH-1:0] integ_q [NUM_CH];
  logic signed [VAL_LENGTH-1:0] integ_d [NUM_CH];
  logic signed [VAL_LENGTH-1:0] ek1_q [NUM_CH];
  logic signed [VAL_LENGTH-1:0] ek1_d [NUM_CH];
`ifdef PID_ANTIWINDUP_EN
  logic [NUM_CH-1:0]            sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
`endif

  logic                         grant_found;
  logic [CH_W-1:0]              grant_ch;
  int                           rr_idx;
  logic signed [VAL_LENGTH-1:0] ek0_new;
  logic signed [VAL_LENGTH:0]   int_sum;
  logic signed [VAL_LENGTH-1:0] int_clamped;
  logic                         freeze;
  logic signed [VAL_LENGTH-1:0] mul_a, mul_b;
  logic signed [PROD_W-1:0]     product, product_shr;
  logic signed [VAL_LENGTH-1:0] term;
  logic signed [SUM_W-1:0]      term_ext, out_max_ext, out_min_ext;
  logic signed [VAL_LENGTH-1:0] sum_clamped;

  // Round-robin arbiter: first pending channel after the last one granted.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    rr_idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && pending_q[CH_W'(rr_idx)]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(rr_idx);
      end
    end
  end

  // Error and integrator update; one extra bit keeps the sum exact before clamping.
  assign ek0_new = sp_q - fb_q;
  assign int_sum = $signed({integ_q[ch_q][VAL_LENGTH-1], integ_q[ch_q]})
                 + $signed({ek0_new[VAL_LENGTH-1], ek0_new});

  always_comb begin
    if (int_sum > $signed({int_max[VAL_LENGTH-1], int_max}))
      int_clamped = int_max;
    else if (int_sum < $signed({int_min[VAL_LENGTH-1], int_min}))
      int_clamped = int_min;
    else
      int_clamped = int_sum[VAL_LENGTH-1:0];
  end

  // Anti-windup holds the integrator while the error would deepen the saturation.
`ifdef PID_ANTIWINDUP_EN
  assign freeze = (sat_hi_q[ch_q] && !ek0_new[VAL_LENGTH-1] && (ek0_new != '0))
               || (sat_lo_q[ch_q] && ek0_new[VAL_LENGTH-1]);
`else
  assign freeze = 1'b0;
`endif

  // Shared multiplier operand select.
  always_comb begin
    mul_a = kp;
    mul_b = ek0_q;
    case (state_q)
      S_MUL_I: begin
        mul_a = ki;
        mul_b = acc_q;
      end
      S_MUL_D: begin
        mul_a = kd;
        mul_b = dif_q;
      end
      default: ;
    endcase
  end

  // Each shifted product is saturated to VAL_LENGTH bits so that three of them
  // always fit the VAL_LENGTH+2 bit sum without wrapping.
  assign product     = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign product_shr = product >>> FRAC;

  always_comb begin
    if (product_shr > TERM_MAX)
      term = {1'b0, {(VAL_LENGTH-1){1'b1}}};
    else if (product_shr < TERM_MIN)
      term = {1'b1, {(VAL_LENGTH-1){1'b0}}};
    else
      term = product_shr[VAL_LENGTH-1:0];
  end

  assign term_ext    = $signed({{2{term[VAL_LENGTH-1]}}, term});
  assign out_max_ext = $signed({{2{out_max[VAL_LENGTH-1]}}, out_max});
  assign out_min_ext = $signed({{2{out_min[VAL_LENGTH-1]}}, out_min});

  always_comb begin
    if (sum_q > out_max_ext)
      sum_clamped = out_max;
    else if (sum_q < out_min_ext)
      sum_clamped = out_min;
    else
      sum_clamped = sum_q[VAL_LENGTH-1:0];
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | bus.req;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    sp_d         = sp_q;
    fb_d         = fb_q;
    ek0_d        = ek0_q;
    acc_d        = acc_q;
    dif_d        = dif_q;
    sum_d        = sum_q;
    out_val_d    = out_val_q;
    out_valid_d  = out_valid_q;
    integ_d      = integ_q;
    ek1_d        = ek1_q;
`ifdef PID_ANTIWINDUP_EN
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          // A request landing in the grant cycle re-arms the channel.
          pending_d[grant_ch] = bus.req[grant_ch];
          last_grant_d        = grant_ch;
          ch_d                = grant_ch;
          sp_d                = bus.sp_bus[int'(grant_ch)*VAL_LENGTH +: VAL_LENGTH];
          fb_d                = bus.fb_bus[int'(grant_ch)*VAL_LENGTH +: VAL_LENGTH];
          state_d             = S_ERR;
        end
      end
      S_ERR: begin
        ek0_d       = ek0_new;
        dif_d       = ek0_new - ek1_q[ch_q];
        ek1_d[ch_q] = ek0_new;
        if (freeze) begin
          acc_d = integ_q[ch_q];
        end else begin
          acc_d         = int_clamped;
          integ_d[ch_q] = int_clamped;
        end
        sum_d   = '0;
        state_d = S_MUL_P;
      end
      S_MUL_P: begin
        sum_d   = sum_q + term_ext;
        state_d = S_MUL_I;
      end
      S_MUL_I: begin
        sum_d   = sum_q + term_ext;
        state_d = S_MUL_D;
      end
      S_MUL_D: begin
        sum_d   = sum_q + term_ext;
        state_d = S_SAT;
      end
      S_SAT: begin
        out_val_d   = sum_clamped;
        out_valid_d = 1'b1;
`ifdef PID_ANTIWINDUP_EN
        sat_hi_d[ch_q] = (sum_q > out_max_ext);
        sat_lo_d[ch_q] = (sum_q < out_min_ext);
`endif
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any sample in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      sp_q         <= '0;
      fb_q         <= '0;
      ek0_q        <= '0;
      acc_q        <= '0;
      dif_q        <= '0;
      sum_q        <= '0;
      out_val_q    <= '0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        integ_q[i] <= '0;
        ek1_q[i]   <= '0;
      end
`ifdef PID_ANTIWINDUP_EN
      sat_hi_q     <= '0;
      sat_lo_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      sp_q         <= sp_d;
      fb_q         <= fb_d;
      ek0_q        <= ek0_d;
      acc_q        <= acc_d;
      dif_q        <= dif_d;
      sum_q        <= sum_d;
      out_val_q    <= out_val_d;
      out_valid_q  <= out_valid_d;
      integ_q      <= integ_d;
      ek1_q        <= ek1_d;
`ifdef PID_ANTIWINDUP_EN
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_val   = out_val_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_sched.sv
// tb_pid_sched -- directed self-checking bench for pid_sched (4 channels,
// 32-bit values, 16 fractional bits). Expected values are hand-computed.
module tb_pid_sched;
  localparam int VL = 32;
  localparam int NC = 4;
  localparam int FR = 16;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic signed [VL-1:0] kp, ki, kd, int_max, int_min, out_max, out_min;
  logic busy;

  int checks       = 0;
  int errors       = 0;
  int xfer_count   = 0;
  int valid_cycles = 0;
  int lat;
  int x0;
  int v0;
  int integ_exp [3] = '{100, 150, 150};
  int rr_ch_exp [4] = '{1, 2, 3, 0};
  int rr_val_exp[4] = '{20, 30, 40, 77};

  pid_sched_if #(.VAL_LENGTH(VL), .NUM_CH(NC)) bus ();

  pid_sched #(.VAL_LENGTH(VL), .NUM_CH(NC), .FRAC(FR)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .int_max   (int_max),
    .int_min   (int_min),
    .out_max   (out_max),
    .out_min   (out_min),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Count valid cycles and completed transfers as seen at each rising edge.
  always @(posedge sys_clk) begin
    if (bus.out_valid) valid_cycles++;
    if (bus.out_valid && bus.out_ready) xfer_count++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    bus.req   = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic set_ch(input int ch, input int sp, input int fb);
    bus.sp_bus[ch*VL +: VL] = sp;
    bus.fb_bus[ch*VL +: VL] = fb;
  endtask

  task automatic pulse_req(input logic [NC-1:0] m);
    @(negedge sys_clk);
    bus.req = m;
    @(negedge sys_clk);
    bus.req = '0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 60) begin
      @(negedge sys_clk);
      cycles++;
    end
    check("valid_within_budget", bus.out_valid, 1);
  endtask

  task automatic expect_result(input string tag, input int ch, input int val);
    int cyc;
    wait_valid(cyc);
    check({tag, "_ch"}, bus.out_ch, ch);
    check({tag, "_val"}, bus.out_val, val);
    @(negedge sys_clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req = '0; bus.sp_bus = '0; bus.fb_bus = '0; bus.out_ready = 1'b1;
    kp = 0; ki = 0; kd = 0;
    int_max = 1000000; int_min = -1000000;
    out_max = 1000000; out_min = -1000000;

    // Reset state
    #2 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_val", bus.out_val, 0);
    sys_rst_n = 1'b1;

    // Proportional only: latency 6 cycles from the grant cycle
    kp = 32'h10000;
    set_ch(0, 100, 40);
    pulse_req(4'b0001);
    check("grant_cycle_idle", busy, 0);
    wait_valid(lat);
    check("latency", lat, 6);
    check("p_out_ch", bus.out_ch, 0);
    check("p_out_val", bus.out_val, 60);
    @(negedge sys_clk);
    check("p_after_xfer_valid", bus.out_valid, 0);
    check("p_after_xfer_busy", busy, 0);

    // Fractional gain 0.5 with arithmetic shift, then output floor clamp
    do_reset();
    kp = 32'h8000;
    set_ch(2, 61, 0);
    pulse_req(4'b0100);
    expect_result("frac_pos", 2, 30);
    set_ch(2, 0, 61);
    pulse_req(4'b0100);
    expect_result("frac_neg", 2, -31);
    out_min = -20;
    pulse_req(4'b0100);
    expect_result("out_min_clamp", 2, -20);
    out_min = -1000000;

    // Derivative only
    do_reset();
    kp = 0; kd = 32'h10000;
    set_ch(1, 50, 0);
    pulse_req(4'b0010);
    expect_result("deriv_first", 1, 50);
    set_ch(1, 80, 0);
    pulse_req(4'b0010);
    expect_result("deriv_second", 1, 30);
    kd = 0;

    // Integral with integrator clamp
    do_reset();
    ki = 32'h10000; int_max = 150;
    set_ch(0, 100, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_req(4'b0001);
      expect_result("integ_clamp", 0, integ_exp[i]);
    end
    ki = 0; int_max = 1000000;

    // Round-robin order; a ch0 request during ch1 is served after ch3
    do_reset();
    kp = 32'h10000;
    for (int i = 0; i < NC; i++) set_ch(i, 10 * (i + 1), 0);
    pulse_req(4'b1111);
    expect_result("rr_first", 0, 10);
    @(negedge sys_clk);
    set_ch(0, 77, 0);
    pulse_req(4'b0001);
    for (int i = 0; i < 4; i++) expect_result("rr_order", rr_ch_exp[i], rr_val_exp[i]);

    // Backpressure: result held for 5 cycles, then exactly one transfer
    do_reset();
    set_ch(0, 60, 0);
    bus.out_ready = 1'b0;
    pulse_req(4'b0001);
    wait_valid(lat);
    x0 = xfer_count;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bus.out_valid, bus.out_ch, bus.out_val}, {1'b1, 2'd0, 32'd60});
      @(negedge sys_clk);
    end
    bus.out_ready = 1'b1;
    @(negedge sys_clk);
    check("bp_released_valid", bus.out_valid, 0);
    repeat (10) @(negedge sys_clk);
    check("bp_single_xfer", xfer_count - x0, 1);

    // Output saturation, then integrator behaviour on the next positive error
    do_reset();
    kp = 32'h7FFF0000; ki = 32'h10000;
    out_max = 500; out_min = -500;
    set_ch(0, 1000, 0);
    pulse_req(4'b0001);
    expect_result("sat_first", 0, 500);
    pulse_req(4'b0001);
    expect_result("sat_second", 0, 500);
    kp = 0; out_max = 5000;
    set_ch(0, 0, 0);
    pulse_req(4'b0001);
`ifdef PID_ANTIWINDUP_EN
    expect_result("windup_integ", 0, 1000);
`else
    expect_result("windup_integ", 0, 2000);
`endif
    ki = 0; out_max = 1000000; out_min = -1000000;

    // Reset during MUL_I aborts the sample
    do_reset();
    kp = 32'h10000;
    set_ch(0, 60, 0);
    pulse_req(4'b0001);
    repeat (3) @(negedge sys_clk);
    check("abort_busy_before", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    v0 = valid_cycles;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);
    check("abort_no_result", valid_cycles - v0, 0);
    set_ch(1, 33, 0);
    pulse_req(4'b0010);
    expect_result("post_abort", 1, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 SHALL have parameter VAL_LENGTH, default 32, meaning data width of all signed values.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of PID channels sharing one multiplier.
REQ-003 SHALL have parameter FRAC, default 16, meaning fractional bits of kp/ki/kd in fixed point.
REQ-004 sys_clk  in  1  single clock; all state on rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NUM_CH  per-channel one-cycle sample request pulse.
REQ-007 sp_bus  in  NUM_CH*VAL_LENGTH  signed setpoints, channel i at bits [i*VAL_LENGTH +: VAL_LENGTH].
REQ-008 fb_bus  in  NUM_CH*VAL_LENGTH  signed feedbacks, same packing.
REQ-009 kp, ki, kd  in  VAL_LENGTH each  signed gains, shared by all channels.
REQ-010 int_max, int_min, out_max, out_min  in  VAL_LENGTH each  signed clamp limits, max >= min.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_ch  out  log2(NUM_CH), minimum 1  channel of the current result.
REQ-014 out_val  out  VAL_LENGTH  signed saturated control output.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 A req[i] pulse SHALL set pending[i]; pending[i] SHALL clear at grant of channel i unless req[i] is high in the same cycle.
REQ-017 In IDLE, with any pending bit set, the block SHALL grant round-robin, searching from last_grant+1 with wrap, and SHALL latch sp_i and fb_i of the granted channel.
REQ-018 FSM states: IDLE -> ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> OUT -> IDLE; each state except OUT SHALL take exactly one cycle.
REQ-019 ERR SHALL compute ek0 = sp - fb, acc = clamp(int[ch] + ek0, int_min, int_max), and dif = ek0 - ek1[ch], and SHALL write acc to int[ch] and ek0 to ek1[ch].
REQ-020 MUL_P, MUL_I and MUL_D SHALL use one shared signed VAL_LENGTH x VAL_LENGTH multiplier on (kp, ek0), (ki, acc) and (kd, dif) respectively.
REQ-021 Each product SHALL be arithmetically shifted right by FRAC and added into a sum register of VAL_LENGTH+2 bits, so no overflow occurs before SAT.
REQ-022 SAT SHALL clamp the sum to [out_min, out_max] into out_val and SHALL record per-channel sat_hi/sat_lo flags.
REQ-023 OUT SHALL hold out_valid, out_ch and out_val stable until out_ready is high; the transfer SHALL complete in that cycle and the FSM SHALL return to IDLE.
REQ-024 Latency from grant cycle to first out_valid cycle SHALL be 6 cycles; with out_ready tied high, throughput SHALL be one result per 7 cycles.
REQ-025 Requests arriving while busy SHALL only set pending bits, and none SHALL be lost.
REQ-026 Changes to gains or limits during a computation SHALL take effect in the state that reads them; no shadowing.

Reset
REQ-027 Reset SHALL force FSM to IDLE; pending, int[], ek1[], sat flags, sum, out_val, out_ch and out_valid to 0; busy to 0; last_grant to NUM_CH-1, so channel 0 wins first.
REQ-028 Reset asserted mid-computation or during OUT SHALL abort with no transfer, and the next result after release SHALL derive only from post-reset requests.

Configuration
REQ-029 Macro PID_ANTIWINDUP_EN defined: ERR SHALL leave int[ch] unchanged and use acc = int[ch] when (sat_hi[ch] and ek0 > 0) or (sat_lo[ch] and ek0 < 0).
REQ-030 Macro PID_ANTIWINDUP_EN undefined: the integral SHALL always update per REQ-019, and sat flags SHALL be unused.

Verification
REQ-031 kp=0x10000, ki=kd=0, sp0=100, fb0=40, req=0001, out_ready=1 -> out_valid 6 cycles after grant, out_ch=0, out_val=60.
REQ-032 ki=0x10000, kp=kd=0, int_max=150, ch0 error 100 requested 3 times -> out_val 100, 150, 150.
REQ-033 req=1111 in one cycle -> results emitted in order ch0, ch1, ch2, ch3; a req=0001 issued during ch1 is served after ch3.
REQ-034 out_ready=0 for 5 cycles at OUT -> out_valid, out_ch and out_val held constant, then exactly one transfer.
REQ-035 kp=0x7FFF0000, error 1000, out_max=500 -> out_val=500; with PID_ANTIWINDUP_EN and ki nonzero, int[0] is frozen on the next positive-error sample.
REQ-036 sys_rst_n pulsed low during MUL_I -> out_valid=0, busy=0 immediately, and no result is emitted for the aborted request.
